dmem_mmio: RTL and testbench
============================

Name: dmem_mmio

Overview:
Data-side memory subsystem directly downstream of the single-cycle CPU data port (daddr/dwdata/dwe in, drdata out). It decodes each access to either word-organised data RAM or a small MMIO block. The MMIO block holds an LED register, a free-running cycle counter, and a byte TX FIFO drained through a valid/ready handshake. Reads are combinational so the CPU completes loads in one cycle; all state updates occur on the rising clock edge.

Parameters:
RAM_WORDS, 1024, number of 32-bit RAM words (power of two)
FIFO_DEPTH, 8, TX FIFO entries (power of two, >=2)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
daddr  input  32  byte address from CPU
dwdata  input  32  store data from CPU
dwe  input  4  byte-lane write enables; lane i writes dwdata[8i+7:8i]
drdata  output  32  load data to CPU, combinational from daddr
leds  output  8  LED register value
tx_data  output  8  FIFO head byte
tx_valid  output  1  FIFO non-empty
tx_ready  input  1  consumer accepts tx_data this cycle

Behaviour:
- Interface rule: one clock (clk); reset is synchronous and active-high, sampled only at posedge clk. Reset has priority over every write and pop in the same cycle.
- Reset values: leds=0, counter=0, FIFO empty (count=0, rd/wr pointers=0), overflow=0, tx_valid=0. tx_data is don't-care while tx_valid=0. RAM contents are not reset.
- Decode for RAM: daddr[31]=0. Word index = daddr[log2(RAM_WORDS)+1:2]. Upper address bits are ignored, so the RAM aliases (wraps). daddr[1:0] is ignored.
- Decode for MMIO: daddr[31]=1. Offset = daddr[7:0]. Unmapped offsets and daddr[30:8] != 0 read 0 and ignore writes.
- RAM reads: drdata = mem[index], combinational. RAM writes: each lane with dwe[i]=1 updates at posedge. A written value is visible on drdata the following cycle, never in the same cycle.
- 0x00 LED: read {24'b0, leds}. A write with dwe[0]=1 loads leds <= dwdata[7:0]. Other lanes are ignored.
- 0x04 COUNTER: read returns the 32-bit counter.
  - Counter increments by 1 every non-reset cycle and wraps 0xFFFFFFFF -> 0.
  - A write with any dwe bit set loads counter <= dwdata. The load replaces the increment that cycle; there is no partial-lane load.
- 0x08 TXDATA: read returns 0. A write with dwe[0]=1 pushes dwdata[7:0].
  - Push while full with no pop that cycle: byte is dropped, overflow <= 1 (sticky).
- 0x0C STATUS: read {16'b0, count[7:0], 5'b0, overflow, full, empty}. count is zero-extended.
  - A write with dwe[0]=1 and dwdata[2]=1 clears overflow. A clear in the same cycle as a new overflow event leaves overflow=1.
- FIFO: tx_valid = (count != 0); tx_data = entry at rd pointer.
  - Pop occurs at posedge when tx_valid && tx_ready.
  - Push and pop in the same cycle: count is unchanged. When full, the push is accepted because the pop frees a slot.
  - Pointers wrap modulo FIFO_DEPTH. count ranges 0..FIFO_DEPTH (width log2(FIFO_DEPTH)+1).
  - tx_data must hold stable while tx_valid=1 && tx_ready=0.
- Reset mid-operation: FIFO is emptied, pending bytes are discarded, tx_valid drops the cycle after the reset edge. RAM holds its data.
- Latency: load 0 cycles (combinational). Store, counter load and FIFO push take effect at the next edge. A byte pushed into an empty FIFO appears on tx_valid/tx_data 1 cycle after the push edge.

Test Plan:
- RAM byte lanes: write 0x11223344 to 0x40 with dwe=4'hF, then 0xAA to 0x40 with dwe=4'b0100 -> read 0x40 = 0x11AA3344; read 0x40+4*RAM_WORDS (alias) = 0x11AA3344.
- Counter: release reset, wait 10 cycles -> read 0x80000004 = 10. Write 0xFFFFFFFE -> 2 cycles later reads 0x00000000 (wrap).
- FIFO fill/overflow: tx_ready=0, push 0x01..0x09 (9 bytes, depth 8) -> status = count 8, full=1, overflow=1, tx_data=0x01. Write status 0x4 -> overflow=0.
- Drain handshake: from the full state, tx_ready=1 for 8 cycles -> tx_data sequence 0x01..0x08, then tx_valid=0, status empty=1, count 0.
- Simultaneous push/pop when full: full FIFO, tx_ready=1, push 0x55 -> count stays 8, 0x55 emerges 8th, overflow stays 0.
- Reset mid-stream: 3 bytes queued, leds=0xA5, assert reset 1 cycle with a concurrent TXDATA write -> tx_valid=0, leds=0, counter=0, status=0x00000001; RAM word previously written unchanged.

Source files
------------

// File: rtl/dmem_mmio.sv
// Data-side memory subsystem: word RAM plus an MMIO block with LEDs, a cycle
// counter and a byte TX FIFO. Loads are combinational; all state moves at posedge clk.
module dmem_mmio #(
  parameter int RAM_WORDS  = 1024,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] daddr,
  input  logic [31:0] dwdata,
  input  logic [3:0]  dwe,
  output logic [31:0] drdata,
  output logic [7:0]  leds,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [7:0] OFF_LED    = 8'h00;
  localparam logic [7:0] OFF_COUNT  = 8'h04;
  localparam logic [7:0] OFF_TXDATA = 8'h08;
  localparam logic [7:0] OFF_STATUS = 8'h0C;

  logic [31:0]   mem [RAM_WORDS];
  logic [7:0]    fifo_mem [FIFO_DEPTH];

  logic [31:0]   counter;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          overflow;

  logic          sel_ram;
  logic          sel_mmio;
  logic [AW-1:0] ram_idx;
  logic [7:0]    offset;
  logic          any_we;

  logic          led_wr;
  logic          cnt_wr;
  logic          push_req;
  logic          clr_req;
  logic          full;
  logic          empty;
  logic          pop;
  logic          push_ok;
  logic          ovf_evt;
  logic [7:0]    count8;

  assign sel_ram  = ~daddr[31];
  assign sel_mmio = daddr[31] & (daddr[30:8] == 23'd0);
  assign ram_idx  = daddr[AW+1:2];
  assign offset   = daddr[7:0];
  assign any_we   = |dwe;

  assign led_wr   = sel_mmio & (offset == OFF_LED) & dwe[0];
  assign cnt_wr   = sel_mmio & (offset == OFF_COUNT) & any_we;
  assign push_req = sel_mmio & (offset == OFF_TXDATA) & dwe[0];
  assign clr_req  = sel_mmio & (offset == OFF_STATUS) & dwe[0] & dwdata[2];

  assign empty    = (count == '0);
  assign full     = (count == CW'(FIFO_DEPTH));
  assign tx_valid = ~empty;
  assign tx_data  = fifo_mem[rd_ptr];
  assign pop      = tx_valid & tx_ready;
  // A push into a full FIFO is still accepted when the same edge pops a byte.
  assign push_ok  = push_req & (~full | pop);
  assign ovf_evt  = push_req & full & ~pop;
  assign count8   = 8'(count);

  always_comb begin
    drdata = 32'd0;
    if (sel_ram) begin
      drdata = mem[ram_idx];
    end else if (sel_mmio) begin
      case (offset)
        OFF_LED:    drdata = {24'd0, leds};
        OFF_COUNT:  drdata = counter;
        OFF_STATUS: drdata = {16'd0, count8, 5'd0, overflow, full, empty};
        default:    drdata = 32'd0;
      endcase
    end
  end

  // RAM has no reset, but a reset cycle still suppresses stores.
  always_ff @(posedge clk) begin
    if (!reset && sel_ram) begin
      for (int i = 0; i < 4; i++) begin
        if (dwe[i]) mem[ram_idx][8*i +: 8] <= dwdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      leds    <= 8'd0;
      counter <= 32'd0;
    end else begin
      if (led_wr) leds <= dwdata[7:0];
      if (cnt_wr) counter <= dwdata;
      else        counter <= counter + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push_ok) fifo_mem[wr_ptr] <= dwdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      if (push_ok && !pop)      count <= count + CW'(1);
      else if (pop && !push_ok) count <= count - CW'(1);
      // A fresh overflow outranks a clear arriving on the same edge.
      if (ovf_evt)      overflow <= 1'b1;
      else if (clr_req) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed bench for dmem_mmio: RAM lanes/aliasing, MMIO registers, TX FIFO
// fill/overflow/drain, push+pop when full, and reset mid-stream.
module tb_dmem_mmio;

  localparam int RAM_WORDS  = 1024;
  localparam int FIFO_DEPTH = 8;

  localparam logic [31:0] A_LED    = 32'h8000_0000;
  localparam logic [31:0] A_COUNT  = 32'h8000_0004;
  localparam logic [31:0] A_TX     = 32'h8000_0008;
  localparam logic [31:0] A_STATUS = 32'h8000_000C;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [3:0]  dwe;
  logic [31:0] drdata;
  logic [7:0]  leds;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  int total = 0;
  int bad   = 0;

  dmem_mmio #(.RAM_WORDS(RAM_WORDS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .daddr    (daddr),
    .dwdata   (dwdata),
    .dwe      (dwe),
    .drdata   (drdata),
    .leds     (leds),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
    daddr  = a;
    dwdata = d;
    dwe    = we;
    tick();
    dwe    = 4'h0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    daddr = a;
    dwe   = 4'h0;
    #1;
    chk(tag, drdata, exp);
  endtask

  initial begin
    reset    = 1'b1;
    daddr    = 32'd0;
    dwdata   = 32'd0;
    dwe      = 4'h0;
    tx_ready = 1'b0;
    tick();
    tick();

    chk("rst_leds", {24'd0, leds}, 32'd0);
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    rd_chk("rst_status", A_STATUS, 32'h0000_0001);
    rd_chk("rst_counter", A_COUNT, 32'd0);

    reset = 1'b0;
    repeat (10) tick();
    rd_chk("counter_10", A_COUNT, 32'd10);

    wr(32'h40, 32'h1122_3344, 4'hF);
    wr(32'h40, 32'h00AA_0000, 4'b0100);
    rd_chk("ram_lane", 32'h40, 32'h11AA_3344);
    rd_chk("ram_alias", 32'h40 + 32'(4 * RAM_WORDS), 32'h11AA_3344);
    rd_chk("ram_low_bits_ignored", 32'h43, 32'h11AA_3344);

    wr(32'h48, 32'hDEAD_BEEF, 4'hF);
    daddr  = 32'h48;
    dwdata = 32'h1234_5678;
    dwe    = 4'hF;
    #1;
    chk("ram_no_same_cycle", drdata, 32'hDEAD_BEEF);
    tick();
    dwe = 4'h0;
    rd_chk("ram_next_cycle", 32'h48, 32'h1234_5678);

    wr(A_LED, 32'h1234_56A5, 4'b1110);
    chk("led_upper_lanes", {24'd0, leds}, 32'd0);
    wr(A_LED, 32'h1234_56A5, 4'b0001);
    chk("led_write", {24'd0, leds}, 32'h0000_00A5);
    rd_chk("led_read", A_LED, 32'h0000_00A5);
    wr(32'h8000_0100, 32'h0000_0055, 4'hF);
    chk("unmapped_write_ignored", {24'd0, leds}, 32'h0000_00A5);
    rd_chk("unmapped_high", 32'h8000_0100, 32'd0);
    rd_chk("unmapped_off", 32'h8000_0010, 32'd0);

    wr(A_COUNT, 32'hFFFF_FFFE, 4'b0010);
    rd_chk("counter_load", A_COUNT, 32'hFFFF_FFFE);
    tick();
    tick();
    rd_chk("counter_wrap", A_COUNT, 32'd0);

    for (int i = 1; i <= 9; i++) wr(A_TX, 32'(i), 4'b0001);
    rd_chk("fifo_full_ovf_status", A_STATUS, 32'h0000_0806);
    chk("fifo_head", {24'd0, tx_data}, 32'h01);
    tick();
    chk("fifo_head_held", {24'd0, tx_data}, 32'h01);
    rd_chk("txdata_reads_zero", A_TX, 32'd0);
    wr(A_STATUS, 32'h0000_0004, 4'b0001);
    rd_chk("ovf_clear", A_STATUS, 32'h0000_0802);

    tx_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("drain_valid_%0d", i), {31'd0, tx_valid}, 32'd1);
      chk($sformatf("drain_data_%0d", i), {24'd0, tx_data}, 32'(i));
      tick();
    end
    chk("drain_done_valid", {31'd0, tx_valid}, 32'd0);
    rd_chk("drain_done_status", A_STATUS, 32'h0000_0001);

    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) wr(A_TX, 32'h10 + 32'(i), 4'b0001);
    rd_chk("refill_status", A_STATUS, 32'h0000_0802);
    tx_ready = 1'b1;
    wr(A_TX, 32'h55, 4'b0001);
    rd_chk("pushpop_full_status", A_STATUS, 32'h0000_0802);
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("pp_data_%0d", i), {24'd0, tx_data}, (i == 8) ? 32'h55 : 32'h10 + 32'(i));
      tick();
    end
    chk("pp_done_valid", {31'd0, tx_valid}, 32'd0);
    rd_chk("pp_done_status", A_STATUS, 32'h0000_0001);
    tx_ready = 1'b0;

    wr(A_TX, 32'h21, 4'b0001);
    wr(A_TX, 32'h22, 4'b0001);
    wr(A_TX, 32'h23, 4'b0001);
    wr(A_LED, 32'hA5, 4'b0001);
    rd_chk("pre_reset_status", A_STATUS, 32'h0000_0300);
    reset  = 1'b1;
    daddr  = A_TX;
    dwdata = 32'h99;
    dwe    = 4'b0001;
    tick();
    reset = 1'b0;
    dwe   = 4'h0;
    chk("mid_rst_valid", {31'd0, tx_valid}, 32'd0);
    chk("mid_rst_leds", {24'd0, leds}, 32'd0);
    rd_chk("mid_rst_counter", A_COUNT, 32'd0);
    rd_chk("mid_rst_status", A_STATUS, 32'h0000_0001);
    rd_chk("mid_rst_ram", 32'h40, 32'h11AA_3344);
    tick();
    rd_chk("post_rst_counter", A_COUNT, 32'd1);
    chk("post_rst_valid", {31'd0, tx_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
